// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
// Used by the receiver today and intended for the transmitter as well.
package uart_pkg;

    // FSM state encodings
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Ticks per bit period, and the tick index at the middle of the start bit
    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the value both flops take during synchronous reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop frame recovery, LSB first.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN, which adds
// the PARITY state, the PARITY_ODD parameter and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            frame_err
);

    logic            rx_s;
    logic [2:0]      state, state_next;
    // 5 bits so the stop-bit count reaches SB_TICK-1 for up to 2 stop bits
    logic [4:0]      s_cnt, s_cnt_next;
    logic [2:0]      n_cnt, n_cnt_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            p_reg, p_next;
    logic            perr_next;
`endif

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    // Next-state and output decode of the receive FSM
    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_cnt_next = n_cnt;
        b_next     = b_reg;
        dout_next  = dout;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
        perr_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == 5'(START_MID)) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            n_cnt_next = '0;
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == 5'(OVERSAMPLE - 1)) begin
                        s_cnt_next = '0;
                        b_next     = {rx_s, b_reg[DBIT-1:1]};
                        if (n_cnt == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_cnt_next = n_cnt + 3'd1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (s_tick) begin
                    if (s_cnt == 5'(OVERSAMPLE - 1)) begin
                        p_next     = rx_s;
                        s_cnt_next = '0;
                        state_next = STOP;
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == 5'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        if (rx_s) begin
                            dout_next = b_reg;
                            done_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                            // XOR of data and parity is 0 for even, 1 for odd
                            perr_next = (^{b_reg, p_reg}) ^ (PARITY_ODD != 0);
`endif
                        end else begin
                            ferr_next = 1'b1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg        <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            s_cnt        <= s_cnt_next;
            n_cnt        <= n_cnt_next;
            b_reg        <= b_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
`ifdef UART_RX_PARITY_EN
            p_reg        <= p_next;
            parity_err   <= perr_next;
`endif
        end
    end

endmodule
